reservation_arbiter: RTL and testbench

RESERVATION_ARBITER -- requirements
Module: reservation_arbiter

---
 rtl/reservation_arbiter.sv | 114 +++++++++++
 tb/tb_reservation_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/reservation_arbiter.sv
// reservation_arbiter: two-core LL/SC reservation tracker with alternating-priority arbitration and bus snoop invalidation
// Ports:
//   CLK, RST          rising-edge clock, asynchronous active-high reset
//   req, op_sc        per-core request (held until ack) and op select (0=LL, 1=SC)
//   addr0, addr1      per-core word address
//   snoop_inv/_addr   external bus write strobe and address
//   ack, sc_ok        one-cycle completion pulse and SC result per core
//   resv_valid        per-core reservation valid
//   busy              FSM not in IDLE
module reservation_arbiter #(
  parameter int AW    = 32,
  parameter int NCORE = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NCORE-1:0] req,
  input  logic [NCORE-1:0] op_sc,
  input  logic [AW-1:0]    addr0,
  input  logic [AW-1:0]    addr1,
  input  logic             snoop_inv,
  input  logic [AW-1:0]    snoop_addr,
  output logic [NCORE-1:0] ack,
  output logic [NCORE-1:0] sc_ok,
  output logic [NCORE-1:0] resv_valid,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, RESP = 2'd2} state_t;
  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             gid_q, gid_d;
  logic             op_q, op_d;
  logic             res_q, res_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [AW-1:0]    resv_addr_q [NCORE];
  logic [AW-1:0]    resv_addr_d [NCORE];
  logic [NCORE-1:0] valid_q, valid_d;
  logic [NCORE-1:0] snoop_hit, after_snoop;
  logic             grant, srv_hit;
  // Snoop invalidation is applied before the SERVE update, so an SC racing a
  // same-address bus write sees its reservation already gone.
  always_comb begin
    for (int i = 0; i < NCORE; i++)
      snoop_hit[i] = snoop_inv && (resv_addr_q[i] == snoop_addr);
    after_snoop = valid_q & ~snoop_hit;
    grant       = (req == 2'b01) ? 1'b0 : (req == 2'b10) ? 1'b1 : ~last_q;
    srv_hit     = after_snoop[gid_q] && (resv_addr_q[gid_q] == addr_q);
  end
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gid_d       = gid_q;
    op_d        = op_q;
    addr_d      = addr_q;
    res_d       = res_q;
    valid_d     = after_snoop;
    resv_addr_d = resv_addr_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = SERVE;
          last_d  = grant;
          gid_d   = grant;
          op_d    = op_sc[grant];
          addr_d  = grant ? addr1 : addr0;
        end
      end
      SERVE: begin
        state_d = RESP;
        res_d   = op_q && srv_hit;
        if (!op_q) begin
          // A same-address snoop in this cycle beats the LL set.
          resv_addr_d[gid_q] = addr_q;
          valid_d[gid_q]     = !(snoop_inv && (snoop_addr == addr_q));
        end else if (srv_hit) begin
          for (int i = 0; i < NCORE; i++)
            if (resv_addr_q[i] == addr_q) valid_d[i] = 1'b0;
        end else begin
          valid_d[gid_q] = 1'b0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gid_q   <= 1'b0;
      op_q    <= 1'b0;
      res_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= '0;
      for (int i = 0; i < NCORE; i++) resv_addr_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gid_q       <= gid_d;
      op_q        <= op_d;
      res_q       <= res_d;
      addr_q      <= addr_d;
      valid_q     <= valid_d;
      resv_addr_q <= resv_addr_d;
    end
  end
  always_comb begin
    for (int i = 0; i < NCORE; i++) begin
      ack[i]   = (state_q == RESP) && (gid_q == i[0]);
      sc_ok[i] = (state_q == RESP) && (gid_q == i[0]) && res_q;
    end
    resv_valid = valid_q;
    busy       = state_q != IDLE;
  end
endmodule

// File: tb/tb_reservation_arbiter.sv
// tb_reservation_arbiter: directed table and corner-case sequences for reservation_arbiter
module tb_reservation_arbiter;
  logic        CLK, RST, snoop_inv, busy;
  logic [1:0]  req, op_sc, ack, sc_ok, resv_valid;
  logic [31:0] addr0, addr1, snoop_addr;
  int checks = 0, errors = 0;
  typedef struct {
    logic rst; logic [1:0] rq, op; logic [31:0] a0, a1; logic sn; logic [31:0] sa;
    logic [1:0] e_ack, e_ok, e_rv; logic e_busy;
  } vec_t;
  vec_t tbl[$];
  reservation_arbiter #(.AW(32), .NCORE(2)) dut (
    .CLK(CLK), .RST(RST), .req(req), .op_sc(op_sc), .addr0(addr0), .addr1(addr1),
    .snoop_inv(snoop_inv), .snoop_addr(snoop_addr), .ack(ack), .sc_ok(sc_ok),
    .resv_valid(resv_valid), .busy(busy)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_all(input string nm, input logic [1:0] ea, input logic [1:0] eo,
                         input logic [1:0] ev, input logic eb);
    chk({nm, ".ack"}, {30'd0, ack}, {30'd0, ea});
    chk({nm, ".sc_ok"}, {30'd0, sc_ok}, {30'd0, eo});
    chk({nm, ".resv_valid"}, {30'd0, resv_valid}, {30'd0, ev});
    chk({nm, ".busy"}, {31'd0, busy}, {31'd0, eb});
  endtask
  task automatic add(input logic r, input logic [1:0] rq, input logic [1:0] op, input logic [31:0] a0,
                     input logic [31:0] a1, input logic sn, input logic [31:0] sa,
                     input logic [1:0] ea, input logic [1:0] eo, input logic [1:0] ev, input logic eb);
    vec_t v;
    v.rst = r; v.rq = rq; v.op = op; v.a0 = a0; v.a1 = a1; v.sn = sn; v.sa = sa;
    v.e_ack = ea; v.e_ok = eo; v.e_rv = ev; v.e_busy = eb;
    tbl.push_back(v);
  endtask
  task automatic drive(input logic [1:0] rq, input logic [1:0] op, input logic [31:0] a0,
                       input logic [31:0] a1, input logic sn, input logic [31:0] sa);
    req = rq; op_sc = op; addr0 = a0; addr1 = a1; snoop_inv = sn; snoop_addr = sa;
  endtask
  initial begin
    RST = 1'b1;
    drive(2'b00, 2'b00, 0, 0, 1'b0, 0);
    tick();
    tick();
    chk_all("reset", 2'b00, 2'b00, 2'b00, 1'b0);
    RST = 1'b0;
    // core 0 LL 0x100 then SC 0x100
    add(0, 2'b01, 2'b00, 32'h100, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1);
    add(0, 2'b01, 2'b00, 32'h100, 0, 0, 0, 2'b01, 2'b00, 2'b01, 1);
    add(0, 2'b00, 2'b00, 32'h100, 0, 0, 0, 2'b00, 2'b00, 2'b01, 0);
    add(0, 2'b01, 2'b01, 32'h100, 0, 0, 0, 2'b00, 2'b00, 2'b01, 1);
    add(0, 2'b01, 2'b01, 32'h100, 0, 0, 0, 2'b01, 2'b01, 2'b00, 1);
    add(0, 2'b00, 2'b00, 32'h100, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    // reset, then both cores LL 0x200 together; core 1 SC ok; core 0 SC fails
    add(1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    add(0, 2'b11, 2'b00, 32'h200, 32'h200, 0, 0, 2'b00, 2'b00, 2'b00, 1);
    add(0, 2'b11, 2'b00, 32'h200, 32'h200, 0, 0, 2'b01, 2'b00, 2'b01, 1);
    add(0, 2'b10, 2'b00, 32'h200, 32'h200, 0, 0, 2'b00, 2'b00, 2'b01, 0);
    add(0, 2'b10, 2'b00, 32'h200, 32'h200, 0, 0, 2'b00, 2'b00, 2'b01, 1);
    add(0, 2'b10, 2'b00, 32'h200, 32'h200, 0, 0, 2'b10, 2'b00, 2'b11, 1);
    add(0, 2'b00, 2'b00, 32'h200, 32'h200, 0, 0, 2'b00, 2'b00, 2'b11, 0);
    add(0, 2'b10, 2'b10, 32'h200, 32'h200, 0, 0, 2'b00, 2'b00, 2'b11, 1);
    add(0, 2'b10, 2'b10, 32'h200, 32'h200, 0, 0, 2'b10, 2'b10, 2'b00, 1);
    add(0, 2'b00, 2'b00, 32'h200, 32'h200, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    add(0, 2'b01, 2'b01, 32'h200, 32'h200, 0, 0, 2'b00, 2'b00, 2'b00, 1);
    add(0, 2'b01, 2'b01, 32'h200, 32'h200, 0, 0, 2'b01, 2'b00, 2'b00, 1);
    add(0, 2'b00, 2'b00, 32'h200, 32'h200, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    foreach (tbl[n]) begin
      RST = tbl[n].rst;
      drive(tbl[n].rq, tbl[n].op, tbl[n].a0, tbl[n].a1, tbl[n].sn, tbl[n].sa);
      tick();
      chk_all($sformatf("vec%0d", n), tbl[n].e_ack, tbl[n].e_ok, tbl[n].e_rv, tbl[n].e_busy);
    end
    // core 1 LL 0x300, idle-cycle snoop 0x300, core 1 SC fails
    drive(2'b10, 2'b00, 0, 32'h300, 0, 0); tick(); tick();
    chk_all("ll300", 2'b10, 2'b00, 2'b10, 1);
    drive(2'b00, 2'b00, 0, 32'h300, 0, 0); tick();
    drive(2'b00, 2'b00, 0, 32'h300, 1, 32'h300); tick();
    chk_all("snoop300", 2'b00, 2'b00, 2'b00, 0);
    drive(2'b10, 2'b10, 0, 32'h300, 0, 0); tick(); tick();
    chk_all("sc300", 2'b10, 2'b00, 2'b00, 1);
    drive(2'b00, 2'b00, 0, 0, 0, 0); tick();
    // core 0 SC 0x400 with same-address snoop in SERVE fails
    drive(2'b01, 2'b00, 32'h400, 0, 0, 0); tick(); tick();
    drive(2'b00, 2'b00, 32'h400, 0, 0, 0); tick();
    chk("ll400.rv", {30'd0, resv_valid}, 32'd1);
    drive(2'b01, 2'b01, 32'h400, 0, 0, 0); tick();
    snoop_inv = 1'b1; snoop_addr = 32'h400; tick();
    chk_all("sc400_snoop_same", 2'b01, 2'b00, 2'b00, 1);
    drive(2'b00, 2'b00, 0, 0, 0, 0); tick();
    // same but snoop to 0x404 leaves the SC intact
    drive(2'b01, 2'b00, 32'h400, 0, 0, 0); tick(); tick();
    drive(2'b00, 2'b00, 32'h400, 0, 0, 0); tick();
    drive(2'b01, 2'b01, 32'h400, 0, 0, 0); tick();
    snoop_inv = 1'b1; snoop_addr = 32'h404; tick();
    chk_all("sc400_snoop_other", 2'b01, 2'b01, 2'b00, 1);
    drive(2'b00, 2'b00, 0, 0, 0, 0); tick();
    // LL with same-address snoop in SERVE: invalidate wins
    drive(2'b01, 2'b00, 32'h500, 0, 0, 0); tick();
    snoop_inv = 1'b1; snoop_addr = 32'h500; tick();
    chk_all("ll500_snoop", 2'b01, 2'b00, 2'b00, 1);
    drive(2'b00, 2'b00, 0, 0, 0, 0); tick();
    // reset during SERVE discards op and reservations
    drive(2'b10, 2'b00, 0, 32'h700, 0, 0); tick(); tick();
    drive(2'b00, 2'b00, 0, 32'h700, 0, 0); tick();
    chk("ll700.rv", {30'd0, resv_valid}, 32'd2);
    drive(2'b01, 2'b00, 32'h600, 0, 0, 0); tick();
    chk("serve600.busy", {31'd0, busy}, 32'd1);
    RST = 1'b1; #1;
    chk_all("rst_mid", 2'b00, 2'b00, 2'b00, 0);
    tick();
    chk_all("rst_hold", 2'b00, 2'b00, 2'b00, 0);
    RST = 1'b0; tick();
    chk_all("after_rst_serve", 2'b00, 2'b00, 2'b00, 1);
    tick();
    chk_all("after_rst_resp", 2'b01, 2'b00, 2'b01, 1);
    drive(2'b00, 2'b00, 0, 0, 0, 0); tick();
    // continuous req=11 alternates grants, one ack every 3 cycles
    RST = 1'b1; tick(); RST = 1'b0;
    drive(2'b11, 2'b00, 32'h800, 32'h900, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("alt%0d.ack", k), {30'd0, ack},
          (k % 3 == 2) ? (((k / 3) % 2 == 1) ? 32'd2 : 32'd1) : 32'd0);
    end
    drive(2'b00, 2'b00, 0, 0, 0, 0); tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
